// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the CPU core's fetch/data ports, the shared memory and the arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_data_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              busy_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i,
        output if_ack_o, if_data_o,
        output d_ack_o, d_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output busy_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_rdata_i,
        input  if_ack_o, if_data_o,
        input  d_ack_o, d_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  busy_o
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Serializes instruction-fetch and load/store accesses onto one fixed-latency memory port.
// Ties are broken round-robin against the last granted port; each access ends with a one-cycle ack.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input logic                  clk_i,
    input logic                  rst_i,
    unified_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_lastGrantD;
    logic              r_selD;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_ifData;
    logic [DATA_W-1:0] r_dRdata;

    logic              w_grant;
    logic              w_grantD;
    logic              w_lastBeat;
    logic              w_memEn;
    logic              w_memWe;
    logic [ADDR_W-1:0] w_memAddr;
    logic [DATA_W-1:0] w_memWdata;
    logic              w_ifAck;
    logic              w_dAck;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // On a tie the port that did not win last time is granted, so data wins the first tie after reset.
    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_grantD   = 1'b0;
        w_lastBeat = (r_cnt == LAST_CNT);
        w_memEn    = 1'b0;
        w_memWe    = 1'b0;
        w_memAddr  = '0;
        w_memWdata = '0;
        w_ifAck    = 1'b0;
        w_dAck     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.if_req_i || bus.d_req_i) begin
                    w_grant  = 1'b1;
                    w_grantD = bus.d_req_i && (!bus.if_req_i || !r_lastGrantD);
                    w_next   = ACCESS;
                end
            end
            ACCESS: begin
                w_memEn    = 1'b1;
                w_memWe    = r_we;
                w_memAddr  = r_addr;
                w_memWdata = r_wdata;
                if (w_lastBeat) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_ifAck = !r_selD;
                w_dAck  = r_selD;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt        <= '0;
            r_lastGrantD <= 1'b0;
            r_selD       <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ifData     <= '0;
            r_dRdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_selD       <= w_grantD;
                        r_lastGrantD <= w_grantD;
                        r_we         <= w_grantD && bus.d_we_i;
                        r_addr       <= w_grantD ? bus.d_addr_i : bus.if_addr_i;
                        r_wdata      <= w_grantD ? bus.d_wdata_i : '0;
                        r_cnt        <= '0;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 4'd1;
                    // Read data is only valid on the final enable cycle; stores capture nothing.
                    if (w_lastBeat) begin
                        if (!r_selD) begin
                            r_ifData <= bus.mem_rdata_i;
                        end else if (!r_we) begin
                            r_dRdata <= bus.mem_rdata_i;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_en_o    = w_memEn;
    assign bus.mem_we_o    = w_memWe;
    assign bus.mem_addr_o  = w_memAddr;
    assign bus.mem_wdata_o = w_memWdata;
    assign bus.if_ack_o    = w_ifAck;
    assign bus.d_ack_o     = w_dAck;
    assign bus.if_data_o   = r_ifData;
    assign bus.d_rdata_o   = r_dRdata;
    assign bus.busy_o      = (r_state != IDLE);

endmodule
